// File: rtl/rainbow_pkg.sv
// Shared types for the rainbow hue sequencer: segment encoding and segment count.
package rainbow_pkg;

  localparam int NUM_SEG = 6;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5
  } seg_t;

  // The last segment wraps back to the first one.
  function automatic seg_t next_seg(input seg_t s);
    return (int'(s) == NUM_SEG - 1) ? S0 : seg_t'(s + 3'd1);
  endfunction

endpackage

// File: rtl/rainbow_tick.sv
// Hue step prescaler: one tick every step_dvsr+1 enabled cycles.
`timescale 1ns/1ps
module rainbow_tick (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] step_dvsr,
  output logic        tick
);

  logic [31:0] q_q;
  logic [31:0] q_d;

  // Using >= lets a divisor lowered below the running count fire immediately.
  assign tick = en && (q_q >= step_dvsr);

  always_comb begin
    q_d = q_q + 32'd1;
    if (!en || tick) begin
      q_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/rainbow_seq.sv
// Rainbow hue sequencer producing three registered PWM duty words.
// Optional brightness scaling is enabled with the RAINBOW_BRIGHT_EN macro.
`timescale 1ns/1ps
module rainbow_seq
  import rainbow_pkg::*;
#(
  parameter int R = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [31:0] step_dvsr,
`ifdef RAINBOW_BRIGHT_EN
  input  logic [R:0]  bright,
`endif
  output logic [R:0]  duty_r,
  output logic [R:0]  duty_g,
  output logic [R:0]  duty_b,
  output logic [2:0]  seg,
  output logic        update
);

  localparam int         MAX_I   = 1 << R;
  localparam logic [R:0] MAX     = MAX_I[R:0];
  localparam logic [R-1:0] LVL_TOP = '1;

  logic         tick;
  logic [R-1:0] lvl_q, lvl_d;
  seg_t         seg_q, seg_d;
  logic [R:0]   raw_r, raw_g, raw_b;
  logic [R:0]   up, dn;
  logic [R:0]   r_d, g_d, b_d;
  logic [R:0]   r_q, g_q, b_q;
  logic         upd_q;

  rainbow_tick u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .step_dvsr(step_dvsr),
    .tick     (tick)
  );

  always_comb begin
    lvl_d = lvl_q;
    seg_d = seg_q;
    if (tick) begin
      if (lvl_q == LVL_TOP) begin
        lvl_d = '0;
        seg_d = next_seg(seg_q);
      end else begin
        lvl_d = lvl_q + 1'b1;
      end
    end
  end

  // Duty words come from the next state so they load on the same edge as lvl/seg.
  assign up = {1'b0, lvl_d};
  assign dn = MAX - up;

  always_comb begin
    raw_r = MAX;
    raw_g = '0;
    raw_b = '0;
    unique case (seg_d)
      S0: begin raw_r = MAX; raw_g = up;  raw_b = '0;  end
      S1: begin raw_r = dn;  raw_g = MAX; raw_b = '0;  end
      S2: begin raw_r = '0;  raw_g = MAX; raw_b = up;  end
      S3: begin raw_r = '0;  raw_g = dn;  raw_b = MAX; end
      S4: begin raw_r = up;  raw_g = '0;  raw_b = MAX; end
      S5: begin raw_r = MAX; raw_g = '0;  raw_b = dn;  end
      default: begin raw_r = MAX; raw_g = '0; raw_b = '0; end
    endcase
  end

`ifdef RAINBOW_BRIGHT_EN
  logic [R:0] gain;

  assign gain = (bright > MAX) ? MAX : bright;

  // Product never exceeds MAX*MAX, so 2R+1 bits hold it exactly.
  function automatic logic [R:0] scale(input logic [R:0] v, input logic [R:0] g);
    logic [2*R:0] p;
    p = {{R{1'b0}}, v} * {{R{1'b0}}, g};
    return p[2*R:R];
  endfunction

  assign r_d = scale(raw_r, gain);
  assign g_d = scale(raw_g, gain);
  assign b_d = scale(raw_b, gain);
`else
  assign r_d = raw_r;
  assign g_d = raw_g;
  assign b_d = raw_b;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_q <= '0;
      seg_q <= S0;
      r_q   <= MAX;
      g_q   <= '0;
      b_q   <= '0;
      upd_q <= 1'b0;
    end else begin
      lvl_q <= lvl_d;
      seg_q <= seg_d;
      r_q   <= r_d;
      g_q   <= g_d;
      b_q   <= b_d;
      upd_q <= tick;
    end
  end

  assign duty_r = r_q;
  assign duty_g = g_q;
  assign duty_b = b_q;
  assign seg    = seg_q;
  assign update = upd_q;

endmodule

// File: tb/tb_rainbow_seq.sv
// Self-checking bench for rainbow_seq (R=4) against a hue-position reference model.
`timescale 1ns/1ps
module tb_rainbow_seq;

  localparam int R     = 4;
  localparam int MAX   = 16;
  localparam int CYCLE = 6 * MAX;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [31:0] step_dvsr = '0;
  logic [R:0]  duty_r, duty_g, duty_b;
  logic [2:0]  seg;
  logic        update;
`ifdef RAINBOW_BRIGHT_EN
  logic [R:0]  bright = 5'd16;
`endif

  rainbow_seq #(.R(R)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .step_dvsr(step_dvsr),
`ifdef RAINBOW_BRIGHT_EN
    .bright   (bright),
`endif
    .duty_r   (duty_r),
    .duty_g   (duty_g),
    .duty_b   (duty_b),
    .seg      (seg),
    .update   (update)
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model: hue position 0..6*MAX-1 plus the cycle count since the last step.
  longint mq   = 0;
  int     mpos = 0;
  int     mupd = 0;
  int     er = MAX, eg = 0, eb = 0;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Colour wheel rule: position -> (r,g,b) raw duty for one channel.
  function automatic int rawDuty(input int pos, input int ch);
    int s, l;
    int rgb[3];
    s = pos / MAX;
    l = pos % MAX;
    case (s)
      0: rgb = '{MAX, l, 0};
      1: rgb = '{MAX - l, MAX, 0};
      2: rgb = '{0, MAX, l};
      3: rgb = '{0, MAX - l, MAX};
      4: rgb = '{l, 0, MAX};
      default: rgb = '{MAX, 0, MAX - l};
    endcase
    return rgb[ch];
  endfunction

  function automatic int effGain();
`ifdef RAINBOW_BRIGHT_EN
    return (int'(bright) > MAX) ? MAX : int'(bright);
`else
    return MAX;
`endif
  endfunction

  task automatic checkAll();
    checkOutput("duty_r", duty_r, er);
    checkOutput("duty_g", duty_g, eg);
    checkOutput("duty_b", duty_b, eb);
    checkOutput("seg", seg, mpos / MAX);
    checkOutput("update", update, mupd);
  endtask

  // One clock: predict from inputs seen at the edge, then compare just after it.
  task automatic applyStimulus();
    bit tick;
    int g;
    tick = en && (mq >= longint'(step_dvsr));
    g = effGain();
    @(posedge clk);
    if (!en || tick) mq = 0;
    else mq++;
    if (tick) mpos = (mpos + 1) % CYCLE;
    mupd = tick ? 1 : 0;
    er = (rawDuty(mpos, 0) * g) / MAX;
    eg = (rawDuty(mpos, 1) * g) / MAX;
    eb = (rawDuty(mpos, 2) * g) / MAX;
    #1;
    checkAll();
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  // Called just after an edge: asserts reset between edges and checks the async effect.
  task automatic doReset(input string tag);
    rst_n = 1'b0;
    #2;
    mq = 0; mpos = 0; mupd = 0; er = MAX; eg = 0; eb = 0;
    checkOutput({tag, ".r"}, duty_r, MAX);
    checkOutput({tag, ".g"}, duty_g, 0);
    checkOutput({tag, ".b"}, duty_b, 0);
    checkOutput({tag, ".seg"}, seg, 0);
    checkOutput({tag, ".update"}, update, 0);
    @(posedge clk);
    #1;
    checkAll();
    rst_n = 1'b1;
  endtask

  task automatic cyclesToUpdate(input int limit, output int n);
    n = 0;
    do begin
      applyStimulus();
      n++;
    end while (!update && n < limit);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, updCount, prevR, prevG, prevB, delta;
    $display("[TB] starting rainbow_seq bench");

    // Reset before any clock edge to prove it is asynchronous.
    #2;
    doReset("rst0");

    // Prescale by 3: 16 steps land exactly at the start of segment 1.
    step_dvsr = 32'd2;
    en = 1'b1;
    updCount = 0;
    for (int i = 0; i < 48; i++) begin
      applyStimulus();
      if (update) updCount++;
    end
    checkOutput("presc.updates", updCount, 16);
    checkOutput("presc.seg", seg, 1);
    checkOutput("presc.r", duty_r, 16);
    checkOutput("presc.g", duty_g, 16);
    checkOutput("presc.b", duty_b, 0);

    runCycles(5);
    doReset("rstMid");

    // Full hue cycle at one step per clock, each step moves one channel by one.
    step_dvsr = 32'd0;
    en = 1'b1;
    prevR = duty_r; prevG = duty_g; prevB = duty_b;
    for (int i = 0; i < CYCLE; i++) begin
      applyStimulus();
      if (update) begin
        delta = (int'(duty_r) > prevR ? int'(duty_r) - prevR : prevR - int'(duty_r))
              + (int'(duty_g) > prevG ? int'(duty_g) - prevG : prevG - int'(duty_g))
              + (int'(duty_b) > prevB ? int'(duty_b) - prevB : prevB - int'(duty_b));
        checkOutput("step.delta", delta, 1);
      end
      prevR = duty_r; prevG = duty_g; prevB = duty_b;
    end
    checkOutput("full.r", duty_r, 16);
    checkOutput("full.g", duty_g, 0);
    checkOutput("full.b", duty_b, 0);
    checkOutput("full.seg", seg, 0);

    // Randomized enable, divisor and (when present) brightness.
    for (int blk = 0; blk < 40; blk++) begin
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) step_dvsr = $urandom_range(0, 6);
`ifdef RAINBOW_BRIGHT_EN
      bright = 5'($urandom_range(0, 20));
`endif
      runCycles($urandom_range(1, 12));
    end
`ifdef RAINBOW_BRIGHT_EN
    bright = 5'd16;
`endif

    // Freeze at segment 2, level 5.
    doReset("rstFrz");
    step_dvsr = 32'd0;
    en = 1'b1;
    runCycles(37);
    checkOutput("frz.seg", seg, 2);
    checkOutput("frz.r", duty_r, 0);
    checkOutput("frz.g", duty_g, 16);
    checkOutput("frz.b", duty_b, 5);
    en = 1'b0;
    step_dvsr = 32'd2;
    runCycles(20);
    checkOutput("frz.heldB", duty_b, 5);
    en = 1'b1;
    cyclesToUpdate(10, n);
    checkOutput("frz.resumeGap", n, 3);

    // Shrinking the divisor below the running count fires on the next edge.
    doReset("rstShr");
    step_dvsr = 32'd100;
    en = 1'b1;
    runCycles(50);
    step_dvsr = 32'd10;
    applyStimulus();
    checkOutput("shrink.tick", update, 1);
    cyclesToUpdate(30, n);
    checkOutput("shrink.gap1", n, 11);
    cyclesToUpdate(30, n);
    checkOutput("shrink.gap2", n, 11);

`ifdef RAINBOW_BRIGHT_EN
    // Brightness scaling at segment 0, level 6.
    doReset("rstBr");
    step_dvsr = 32'd0;
    en = 1'b1;
    runCycles(6);
    en = 1'b0;
    bright = 5'd8;
    applyStimulus();
    checkOutput("bright8.r", duty_r, 8);
    checkOutput("bright8.g", duty_g, 3);
    checkOutput("bright8.b", duty_b, 0);
    bright = 5'd20;
    applyStimulus();
    checkOutput("bright20.r", duty_r, 16);
    checkOutput("bright20.g", duty_g, 6);
    checkOutput("bright20.b", duty_b, 0);
    bright = 5'd16;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/rainbow_seq.md
RAINBOW_SEQ -- requirements
Module: rainbow_seq

Interface
REQ-001 Parameter: R, default 8, duty resolution; full scale MAX = 2**R; duty ports are R+1 bits wide so MAX is representable.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  high: sequence advances; low: sequence frozen.
REQ-005 step_dvsr  input  32  hue step prescale; one step every step_dvsr+1 clk cycles.
REQ-006 duty_r, duty_g, duty_b  output  R+1 each  duty words for three downstream PWM channels (value v gives v/MAX on-fraction).
REQ-007 seg  output  3  current hue segment, 0..5.
REQ-008 update  output  1  one-cycle pulse, high in the cycle after duty outputs change due to a step.

Function
REQ-009 Prescaler q (32 bit) SHALL count 0..step_dvsr; step tick asserted when en=1 and q >= step_dvsr; q returns to 0 on tick, else increments.
REQ-010 The ">=" compare SHALL make a mid-count step_dvsr decrease below q produce a tick on the next cycle, with no 2**32 wrap.
REQ-011 step_dvsr=0 SHALL produce a tick every cycle while en=1.
REQ-012 en=0 SHALL clear q to 0 and hold lvl, seg, duty outputs; update SHALL be 0.
REQ-013 Level counter lvl (R bits) SHALL increment on each tick; at lvl=MAX-1 a tick SHALL set lvl=0 and advance seg; seg 5 SHALL wrap to 0.
REQ-014 Segment states and raw duty mapping (L = lvl), as (r, g, b):
  S0 RG_UP: MAX, L, 0
  S1 R_DN: MAX-L, MAX, 0
  S2 B_UP: 0, MAX, L
  S3 G_DN: 0, MAX-L, MAX
  S4 R_UP: L, 0, MAX
  S5 B_DN: MAX, 0, MAX-L
REQ-015 Every step SHALL change exactly one channel by exactly 1, including at segment boundaries and the 5->0 wrap.
REQ-016 One full hue cycle SHALL be 6*MAX ticks.
REQ-017 Duty outputs SHALL be registered and loaded on the same edge as the lvl/seg update (computed from next state); no combinational path from inputs to outputs.
REQ-018 update SHALL be registered: high for exactly one cycle following each tick edge.

Reset
REQ-019 rst_n low SHALL immediately force q=0, lvl=0, seg=0, duty_r=MAX, duty_g=0, duty_b=0, update=0, regardless of clk.
REQ-020 Reset asserted mid-segment SHALL discard all progress; after release, the first tick occurs step_dvsr+1 cycles after en is sampled high.

Configuration
REQ-021 Macro RAINBOW_BRIGHT_EN: when defined, input port bright (R+1 bits, 0..MAX) SHALL exist and each output SHALL equal (raw*bright)>>R, registered every cycle (one-cycle latency from bright change, independent of ticks); bright>MAX SHALL be clamped to MAX.
REQ-022 Without RAINBOW_BRIGHT_EN: no bright port, outputs equal raw duty per REQ-014, no multipliers synthesized.

Structure
REQ-023 Package rainbow_pkg SHALL hold seg_t enum (S0..S5, 3-bit), and the NUM_SEG=6 constant.
REQ-024 Prescaler SHALL be a sub-module rainbow_tick (clk, rst_n, en, step_dvsr -> tick).

Verification (R=4, MAX=16)
REQ-025 Reset: rst_n=0 mid-run -> same-cycle outputs r=16, g=0, b=0, seg=0, update=0.
REQ-026 Prescale: step_dvsr=2, en=1 -> update every 3rd cycle; after 16 ticks seg=1, r=16, g=16, b=0.
REQ-027 Full cycle: step_dvsr=0 -> 96 ticks return to r=16,g=0,b=0,seg=0; every step a single channel changes by 1 (scoreboard).
REQ-028 Freeze: en=0 for 20 cycles at seg=2,lvl=5 -> outputs held (0,16,5), update=0; en=1 -> next tick 3 cycles later (step_dvsr=2).
REQ-029 Divisor shrink: step_dvsr=100, at q=50 set step_dvsr=10 -> tick next cycle, then every 11 cycles.
REQ-030 RAINBOW_BRIGHT_EN: bright=8 at seg=0,lvl=6 -> r=8, g=3, b=0; bright=20 -> treated as 16 (full raw).
